// File: rtl/branch_update_scheduler_if.sv
// Bundle of fetch, execute and predictor-side signals around the branch
// update scheduler.
//   slave  : scheduler view (takes fetch/execute requests, drives predictor)
//   master : environment view (fetch/execute drivers, predictor observer)
// Signals:
//   iFLUSH                              predictor flush
//   iUPD_VALID/HIT/ADDR/INST_ADDR       resolved-branch update from execute
//   oUPD_READY                          update accepted when valid
//   iFETCH_SEARCH_REQ/ADDR              fetch lookup request
//   oFETCH_SEARCH_STALL                 lookup refused this cycle
//   oBP_SEARCH_STB/INST_ADDR            search port to predictor
//   oBP_JUMP_STB/HIT/ADDR/INST_ADDR     update port to predictor
//   oQUEUE_COUNT                        update FIFO occupancy
interface branch_update_scheduler_if #(
    parameter int DEPTH = 4
);
    logic                         iFLUSH;
    logic                         iUPD_VALID;
    logic                         oUPD_READY;
    logic                         iUPD_HIT;
    logic [31:0]                  iUPD_ADDR;
    logic [31:0]                  iUPD_INST_ADDR;
    logic                         iFETCH_SEARCH_REQ;
    logic [31:0]                  iFETCH_SEARCH_ADDR;
    logic                         oFETCH_SEARCH_STALL;
    logic                         oBP_SEARCH_STB;
    logic [31:0]                  oBP_SEARCH_INST_ADDR;
    logic                         oBP_JUMP_STB;
    logic                         oBP_JUMP_HIT;
    logic [31:0]                  oBP_JUMP_ADDR;
    logic [31:0]                  oBP_JUMP_INST_ADDR;
    logic [$clog2(DEPTH+1)-1:0]   oQUEUE_COUNT;

    modport slave (
        input  iFLUSH, iUPD_VALID, iUPD_HIT, iUPD_ADDR, iUPD_INST_ADDR,
               iFETCH_SEARCH_REQ, iFETCH_SEARCH_ADDR,
        output oUPD_READY, oFETCH_SEARCH_STALL, oBP_SEARCH_STB,
               oBP_SEARCH_INST_ADDR, oBP_JUMP_STB, oBP_JUMP_HIT,
               oBP_JUMP_ADDR, oBP_JUMP_INST_ADDR, oQUEUE_COUNT
    );

    modport master (
        output iFLUSH, iUPD_VALID, iUPD_HIT, iUPD_ADDR, iUPD_INST_ADDR,
               iFETCH_SEARCH_REQ, iFETCH_SEARCH_ADDR,
        input  oUPD_READY, oFETCH_SEARCH_STALL, oBP_SEARCH_STB,
               oBP_SEARCH_INST_ADDR, oBP_JUMP_STB, oBP_JUMP_HIT,
               oBP_JUMP_ADDR, oBP_JUMP_INST_ADDR, oQUEUE_COUNT
    );
endinterface

// File: rtl/branch_update_scheduler.sv
// Branch update scheduler: shares the predictor's single table port between
// fetch lookups (priority) and queued execute-side updates. Updates wait in a
// small FIFO and drain in idle slots; after STARVE_LIMIT consecutive lost
// slots one update is forced through and fetch is stalled for that cycle.
// Ports:
//   iCLOCK   clock
//   inRESET  asynchronous active-low reset
//   bus      branch_update_scheduler_if.slave (see interface header)
module branch_update_scheduler #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                          iCLOCK,
    input  logic                          inRESET,
    branch_update_scheduler_if.slave      bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SW    = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHARE = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_next_s;
    logic [SW-1:0]      starve_r;
    logic [SW-1:0]      starve_next_s;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic               hit_mem_r  [DEPTH];
    logic [31:0]        addr_mem_r [DEPTH];
    logic [31:0]        inst_mem_r [DEPTH];

    logic               full_s;
    logic               upd_ready_s;
    logic               push_s;
    logic               pop_s;
    logic               search_stb_s;
    logic               stall_s;

    // Port grant, FIFO push/pop decisions and next-state computation.
    always_comb begin
        search_stb_s  = 1'b0;
        pop_s         = 1'b0;
        stall_s       = 1'b0;
        starve_next_s = starve_r;
        state_next_s  = state_r;
        count_next_s  = count_r;

        full_s      = (count_r == CNT_W'(DEPTH));
        upd_ready_s = !full_s && !bus.iFLUSH;
        push_s      = bus.iUPD_VALID && upd_ready_s;

        if (bus.iFLUSH) begin
            // Flush beats everything, including a forced slot; lookups still pass.
            search_stb_s  = bus.iFETCH_SEARCH_REQ;
            starve_next_s = '0;
            count_next_s  = '0;
            state_next_s  = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    search_stb_s = bus.iFETCH_SEARCH_REQ;
                end
                ST_SHARE: begin
                    if (bus.iFETCH_SEARCH_REQ) begin
                        search_stb_s  = 1'b1;
                        starve_next_s = starve_r + SW'(1);
                    end else begin
                        pop_s         = 1'b1;
                        starve_next_s = '0;
                    end
                end
                ST_FORCE: begin
                    pop_s         = 1'b1;
                    stall_s       = bus.iFETCH_SEARCH_REQ;
                    starve_next_s = '0;
                end
                default: begin
                    starve_next_s = '0;
                end
            endcase

            count_next_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);

            // A lookup that wins the last allowed slot arms the forced drain.
            if ((state_r == ST_SHARE) && search_stb_s &&
                (starve_r == SW'(STARVE_LIMIT - 1))) begin
                state_next_s = ST_FORCE;
            end else if (count_next_s == CNT_W'(0)) begin
                state_next_s = ST_IDLE;
            end else begin
                state_next_s = ST_SHARE;
            end
        end
    end

    // Control state: FSM, occupancy, starvation counter and FIFO pointers.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_r  <= ST_IDLE;
            count_r  <= '0;
            starve_r <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            state_r  <= state_next_s;
            count_r  <= count_next_s;
            starve_r <= starve_next_s;
            if (bus.iFLUSH) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                end
            end
        end
    end

    // Update FIFO storage; a pushed entry becomes visible at the head next cycle.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                hit_mem_r[i]  <= 1'b0;
                addr_mem_r[i] <= 32'h0;
                inst_mem_r[i] <= 32'h0;
            end
        end else if (push_s) begin
            hit_mem_r[wr_ptr_r]  <= bus.iUPD_HIT;
            addr_mem_r[wr_ptr_r] <= bus.iUPD_ADDR;
            inst_mem_r[wr_ptr_r] <= bus.iUPD_INST_ADDR;
        end
    end

    // Outputs follow the current-cycle grant; reset forces them to idle values
    // at once, without waiting for a clock edge.
    assign bus.oUPD_READY           = !inRESET || upd_ready_s;
    assign bus.oBP_SEARCH_STB       = inRESET && search_stb_s;
    assign bus.oBP_SEARCH_INST_ADDR = (inRESET && search_stb_s) ? bus.iFETCH_SEARCH_ADDR : 32'h0;
    assign bus.oBP_JUMP_STB         = inRESET && pop_s;
    assign bus.oBP_JUMP_HIT         = (inRESET && pop_s) ? hit_mem_r[rd_ptr_r] : 1'b0;
    assign bus.oBP_JUMP_ADDR        = (inRESET && pop_s) ? addr_mem_r[rd_ptr_r] : 32'h0;
    assign bus.oBP_JUMP_INST_ADDR   = (inRESET && pop_s) ? inst_mem_r[rd_ptr_r] : 32'h0;
    assign bus.oFETCH_SEARCH_STALL  = inRESET && stall_s;
    assign bus.oQUEUE_COUNT         = count_r;
endmodule

// File: tb/tb_branch_update_scheduler.sv
module tb_branch_update_scheduler;
    localparam int DEPTH = 4;
    localparam int LIM   = 8;

    logic clk;
    logic rst_n;

    branch_update_scheduler_if #(.DEPTH(DEPTH)) bus ();

    branch_update_scheduler #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
        .iCLOCK (clk),
        .inRESET(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hit;
        logic [31:0] addr;
        logic [31:0] inst;
    } upd_t;

    // Reference model: pending updates in arrival order, plus how many slots
    // in a row the oldest pending update has lost to a lookup.
    upd_t q[$];
    int   waited;
    int   total;
    int   bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic h, input logic [31:0] a,
                         input logic [31:0] ia, input logic req,
                         input logic [31:0] sa, input logic fl);
        bus.iUPD_VALID         = v;
        bus.iUPD_HIT           = h;
        bus.iUPD_ADDR          = a;
        bus.iUPD_INST_ADDR     = ia;
        bus.iFETCH_SEARCH_REQ  = req;
        bus.iFETCH_SEARCH_ADDR = sa;
        bus.iFLUSH             = fl;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".rdy"},   32'(bus.oUPD_READY), 32'd1);
        chk({tag, ".sstb"},  32'(bus.oBP_SEARCH_STB), 32'd0);
        chk({tag, ".saddr"}, bus.oBP_SEARCH_INST_ADDR, 32'd0);
        chk({tag, ".jstb"},  32'(bus.oBP_JUMP_STB), 32'd0);
        chk({tag, ".jhit"},  32'(bus.oBP_JUMP_HIT), 32'd0);
        chk({tag, ".jaddr"}, bus.oBP_JUMP_ADDR, 32'd0);
        chk({tag, ".jinst"}, bus.oBP_JUMP_INST_ADDR, 32'd0);
        chk({tag, ".stall"}, 32'(bus.oFETCH_SEARCH_STALL), 32'd0);
        chk({tag, ".cnt"},   32'(bus.oQUEUE_COUNT), 32'd0);
    endtask

    // One clock cycle: inputs already driven at the falling edge; predict the
    // port decision from the model, compare, advance the model, clock.
    task automatic cyc(input string tag);
        logic jump, search, stall, ready;
        upd_t h;
        #1;
        ready  = !bus.iFLUSH && (q.size() < DEPTH);
        jump   = 1'b0;
        search = 1'b0;
        stall  = 1'b0;
        if (bus.iFLUSH || q.size() == 0) begin
            search = bus.iFETCH_SEARCH_REQ;
        end else if (waited >= LIM) begin
            jump  = 1'b1;
            stall = bus.iFETCH_SEARCH_REQ;
        end else if (bus.iFETCH_SEARCH_REQ) begin
            search = 1'b1;
        end else begin
            jump = 1'b1;
        end
        h = '{1'b0, 32'h0, 32'h0};
        if (jump) h = q[0];

        chk({tag, ".rdy"},   32'(bus.oUPD_READY), 32'(ready));
        chk({tag, ".sstb"},  32'(bus.oBP_SEARCH_STB), 32'(search));
        chk({tag, ".saddr"}, bus.oBP_SEARCH_INST_ADDR, search ? bus.iFETCH_SEARCH_ADDR : 32'h0);
        chk({tag, ".jstb"},  32'(bus.oBP_JUMP_STB), 32'(jump));
        chk({tag, ".jhit"},  32'(bus.oBP_JUMP_HIT), 32'(h.hit));
        chk({tag, ".jaddr"}, bus.oBP_JUMP_ADDR, h.addr);
        chk({tag, ".jinst"}, bus.oBP_JUMP_INST_ADDR, h.inst);
        chk({tag, ".stall"}, 32'(bus.oFETCH_SEARCH_STALL), 32'(stall));
        chk({tag, ".cnt"},   32'(bus.oQUEUE_COUNT), 32'(q.size()));

        if (bus.iFLUSH) begin
            q.delete();
            waited = 0;
        end else begin
            if (jump) begin
                void'(q.pop_front());
                waited = 0;
            end else if (search && q.size() > 0) begin
                waited++;
            end
            if (bus.iUPD_VALID && ready)
                q.push_back('{bus.iUPD_HIT, bus.iUPD_ADDR, bus.iUPD_INST_ADDR});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        waited = 0;
        rst_n  = 1'b0;
        // Lookup request held high to show reset masks the strobe.
        drive(1'b1, 1'b1, 32'h5, 32'h6, 1'b1, 32'h1234, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        q.delete();
        waited = 0;

        // Single update drains in the first idle slot.
        drive(1'b1, 1'b1, 32'h100, 32'h80, 1'b0, 32'h0, 1'b0);
        cyc("tp1_push");
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("tp1_jstb_const", 32'(bus.oBP_JUMP_STB), 32'd1);
        chk("tp1_jaddr_const", bus.oBP_JUMP_ADDR, 32'h100);
        chk("tp1_jinst_const", bus.oBP_JUMP_INST_ADDR, 32'h80);
        cyc("tp1_pop");
        chk("tp1_cnt_zero", 32'(bus.oQUEUE_COUNT), 32'd0);

        // Starvation: LIM lookups win, then one forced update with stall.
        drive(1'b1, 1'b0, 32'h200, 32'h90, 1'b1, 32'h4000, 1'b0);
        cyc("tp2_push");
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h4004, 1'b0);
        for (int i = 0; i < LIM; i++) begin
            #1;
            chk("tp2_search_const", 32'(bus.oBP_SEARCH_STB), 32'd1);
            cyc("tp2_search");
        end
        #1;
        chk("tp2_force_jstb", 32'(bus.oBP_JUMP_STB), 32'd1);
        chk("tp2_force_stall", 32'(bus.oFETCH_SEARCH_STALL), 32'd1);
        cyc("tp2_force");
        #1;
        chk("tp2_resume", 32'(bus.oBP_SEARCH_STB), 32'd1);
        cyc("tp2_resume");

        // Overfill under constant lookups.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'($urandom), $urandom, $urandom, 1'b1, $urandom, 1'b0);
            cyc("tp3_fill");
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++) cyc("tp3_drain");

        // Simultaneous push and pop at count 2.
        drive(1'b1, 1'b0, 32'hA0, 32'hA1, 1'b1, 32'h10, 1'b0);
        cyc("tp4_a");
        drive(1'b1, 1'b1, 32'hB0, 32'hB1, 1'b1, 32'h14, 1'b0);
        cyc("tp4_b");
        drive(1'b1, 1'b0, 32'hC0, 32'hC1, 1'b0, 32'h0, 1'b0);
        cyc("tp4_pushpop");
        chk("tp4_cnt_two", 32'(bus.oQUEUE_COUNT), 32'd2);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("tp4_drain");

        // Flush while a forced slot is due, with three entries queued.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'($urandom), $urandom, $urandom, 1'b1, $urandom, 1'b0);
            cyc("tp5_fill");
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h20, 1'b0);
        for (int i = 0; i < 20 && waited < LIM; i++) cyc("tp5_wait");
        chk("tp5_reached_force", 32'(waited), 32'(LIM));
        chk("tp5_cnt_three", 32'(bus.oQUEUE_COUNT), 32'd3);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h24, 1'b1);
        #1;
        chk("tp5_flush_nojump", 32'(bus.oBP_JUMP_STB), 32'd0);
        cyc("tp5_flush");
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("tp5_post_cnt", 32'(bus.oQUEUE_COUNT), 32'd0);
        chk("tp5_post_rdy", 32'(bus.oUPD_READY), 32'd1);
        cyc("tp5_post");

        // Asynchronous reset while draining with two entries left.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'($urandom), $urandom, $urandom, 1'b1, $urandom, 1'b0);
            cyc("tp6_fill");
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc("tp6_drain");
        chk("tp6_cnt_two", 32'(bus.oQUEUE_COUNT), 32'd2);
        #1;
        chk("tp6_mid_jstb", 32'(bus.oBP_JUMP_STB), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset("tp6_async");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        waited = 0;
        cyc("tp6_after0");
        cyc("tp6_after1");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom), $urandom, $urandom,
                  ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 31) == 0));
            cyc("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_update_scheduler.md
Name: branch_update_scheduler

Overview:
- Arbitrates the branch predictor's single table port between fetch-side searches and execute-side resolved-branch updates.
- Buffers resolved updates in a small FIFO. Searches get priority; queued updates drain in idle slots.
- A starvation counter forces one update slot, and stalls fetch, when updates have waited too long.
- Sits between fetch/execute and the branch predictor's search/jump ports.

Parameters:
- DEPTH, 4, update FIFO entries; power of two, ≥2
- STARVE_LIMIT, 8, consecutive search-won cycles with a non-empty queue before a forced update slot; ≥1

Ports:
- iCLOCK  in  1  clock
- inRESET  in  1  asynchronous active-low reset
- iFLUSH  in  1  predictor flush; discards queued updates
- iUPD_VALID  in  1  resolved-branch update offered by execute
- oUPD_READY  out  1  update accepted this cycle when iUPD_VALID=1
- iUPD_HIT  in  1  branch was taken
- iUPD_ADDR  in  32  branch target address
- iUPD_INST_ADDR  in  32  branch instruction address
- iFETCH_SEARCH_REQ  in  1  fetch wants a prediction lookup
- iFETCH_SEARCH_ADDR  in  32  lookup instruction address
- oFETCH_SEARCH_STALL  out  1  lookup not performed this cycle; fetch must hold and retry
- oBP_SEARCH_STB  out  1  search strobe to predictor
- oBP_SEARCH_INST_ADDR  out  32  search address to predictor
- oBP_JUMP_STB  out  1  update strobe to predictor
- oBP_JUMP_HIT  out  1  update taken flag
- oBP_JUMP_ADDR  out  32  update target
- oBP_JUMP_INST_ADDR  out  32  update instruction address
- oQUEUE_COUNT  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset state: FIFO empty, counter 0, FSM IDLE.
  - Outputs under reset: oUPD_READY=1; all strobes and oFETCH_SEARCH_STALL=0; addresses 0; count 0.
  - Reset mid-drain drops all entries.
- FIFO push: iUPD_VALID && oUPD_READY.
  - oUPD_READY = !full && !iFLUSH (full = count==DEPTH).
  - No bypass: a pushed entry is issuable from the next cycle.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo DEPTH.
- Port grant is combinational from current state; exactly one of oBP_SEARCH_STB / oBP_JUMP_STB is high per cycle, or neither.
- FSM states:
  - IDLE (queue empty):
    - oBP_SEARCH_STB = iFETCH_SEARCH_REQ; no jump.
    - Go to SHARE when count becomes non-zero.
  - SHARE (queue non-empty, not forced):
    - If iFETCH_SEARCH_REQ: search granted, counter++.
      - If counter was STARVE_LIMIT-1, next state FORCE.
    - Else: head update issued (jump outputs = head fields, pop), counter=0.
      - Next IDLE if the queue empties, else SHARE.
  - FORCE:
    - Head update issued and popped; search blocked.
    - oFETCH_SEARCH_STALL = iFETCH_SEARCH_REQ.
    - counter=0; next SHARE or IDLE by remaining count.
- oFETCH_SEARCH_STALL is 0 in IDLE and SHARE.
- Jump output fields are 0 when oBP_JUMP_STB=0.
- oBP_SEARCH_INST_ADDR = iFETCH_SEARCH_ADDR whenever oBP_SEARCH_STB=1, else 0.
- iFLUSH (synchronous, 1 cycle):
  - Same cycle: no jump issued, no push accepted, search still passes as in IDLE.
  - Next edge: count=0, counter=0, FSM IDLE.
  - Flush has priority over FORCE.
- Counter width $clog2(STARVE_LIMIT+1); it never exceeds STARVE_LIMIT-1 outside FORCE.
- Worst-case update latency from a queue head: STARVE_LIMIT+1 cycles.

Test Plan:
- Reset, push 1 update (HIT=1, ADDR=0x100, INST=0x80), no search → next cycle oBP_JUMP_STB=1 with those fields; count 1→0; FSM back to IDLE.
- STARVE_LIMIT=8, continuous search, 1 queued update → 8 cycles of oBP_SEARCH_STB; 9th cycle oBP_JUMP_STB=1, oFETCH_SEARCH_STALL=1; 10th cycle search resumes.
- Push 5 updates with DEPTH=4 and constant search → oUPD_READY=0 after 4 accepts, count=4; 5th accepted the cycle after the first forced pop.
- Simultaneous push and pop at count=2 → count stays 2; FIFO order preserved across pointer wrap (8 pushes, 8 pops, addresses in order).
- iFLUSH with count=3 while in FORCE → no jump strobe that cycle; next cycle count=0, IDLE, oUPD_READY=1.
- inRESET low mid-drain with count=2 → all outputs at reset values immediately (asynchronously); no jump strobe after release.
